// File: rtl/icetap_capture_ctrl.sv
// icetap_capture_ctrl: trigger/capture engine of the icetap logic analyzer.
// Streams qualified samples of signals_in into the capture RAM as a circular
// pre-trigger buffer followed by a fixed-length post-trigger window.
// Optional feature macro: ICETAP_TIMESTAMP_EN prepends a saturating
// inter-write delta timestamp to every stored sample.
module icetap_capture_ctrl #(
    parameter int NR_SIGNALS = 8,
    parameter int ADDR_BITS  = 8,
    parameter int TS_BITS    = 8,
`ifdef ICETAP_TIMESTAMP_EN
    localparam int RAM_DATA_BITS = NR_SIGNALS + TS_BITS
`else
    // no timestamp field in this build
    localparam int RAM_DATA_BITS = NR_SIGNALS + 0 * TS_BITS
`endif
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      cmd_start,
    input  logic                      cmd_abort,
    input  logic [3*NR_SIGNALS-1:0]   store_mask,
    input  logic [3*NR_SIGNALS-1:0]   trigger_mask,
    input  logic [ADDR_BITS-1:0]      post_trig_cnt,
    input  logic [NR_SIGNALS-1:0]     signals_in,
    output logic                      ram_wr_ena,
    output logic [ADDR_BITS-1:0]      ram_wr_addr,
    output logic [RAM_DATA_BITS-1:0]  ram_wr_data,
    output logic [1:0]                state,
    output logic                      wrapped,
    output logic [ADDR_BITS-1:0]      trigger_addr,
    output logic [ADDR_BITS-1:0]      stop_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  cur_state;
    state_t                  nxt_state;
    logic [NR_SIGNALS-1:0]   s1;
    logic [NR_SIGNALS-1:0]   s2;
    logic [ADDR_BITS-1:0]    wr_addr;
    logic [ADDR_BITS-1:0]    post_cnt;
    logic                    store_hit;
    logic                    trig_hit;
    logic                    wr_now;
    logic                    arm_now;
    logic                    trig_now;
    logic                    stop_now;
`ifdef ICETAP_TIMESTAMP_EN
    logic [TS_BITS-1:0]      ts;
`endif

    // One 3-bit qualifier code against the current/previous sample of a signal
    function automatic logic code_match(input logic [2:0] code, input logic cur, input logic prev);
        case (code)
            3'b001:  return cur;
            3'b010:  return ~cur;
            3'b011:  return cur ^ prev;
            3'b101:  return cur & ~prev;
            3'b110:  return ~cur & prev;
            default: return 1'b1;
        endcase
    endfunction

    assign state = cur_state;

    // Two-stage sample pipeline: s1 is the current sample, s2 the previous one
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= signals_in;
            s2 <= s1;
        end
    end

    // AND-reduce the per-signal store and trigger qualifiers
    always_comb begin
        store_hit = 1'b1;
        trig_hit  = 1'b1;
        for (int unsigned i = 0; i < NR_SIGNALS; i++) begin
            store_hit = store_hit & code_match(store_mask[3*i +: 3], s1[i], s2[i]);
            trig_hit  = trig_hit  & code_match(trigger_mask[3*i +: 3], s1[i], s2[i]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state decode and per-cycle write/trigger/stop decisions
    always_comb begin
        nxt_state = cur_state;
        wr_now    = 1'b0;
        arm_now   = 1'b0;
        trig_now  = 1'b0;
        stop_now  = 1'b0;
        if (cmd_abort) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE, DONE: begin
                    if (cmd_start) begin
                        nxt_state = ARMED;
                        arm_now   = 1'b1;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        wr_now   = 1'b1;
                        trig_now = 1'b1;
                        if (post_trig_cnt == '0) begin
                            nxt_state = DONE;
                            stop_now  = 1'b1;
                        end else begin
                            nxt_state = POST;
                        end
                    end else if (store_hit) begin
                        wr_now = 1'b1;
                    end
                end
                POST: begin
                    if (store_hit) begin
                        wr_now = 1'b1;
                        if (post_cnt == ADDR_BITS'(1)) begin
                            nxt_state = DONE;
                            stop_now  = 1'b1;
                        end
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // RAM write port, address bookkeeping and capture result registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ram_wr_ena   <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            wr_addr      <= '0;
            post_cnt     <= '0;
            wrapped      <= 1'b0;
            trigger_addr <= '0;
            stop_addr    <= '0;
        end else begin
            ram_wr_ena <= wr_now;
            if (arm_now) begin
                wr_addr <= '0;
                wrapped <= 1'b0;
            end
            if (wr_now) begin
                ram_wr_addr <= wr_addr;
`ifdef ICETAP_TIMESTAMP_EN
                ram_wr_data <= {ts, s1};
`else
                ram_wr_data <= s1;
`endif
                wr_addr <= wr_addr + 1'b1;
                if (cur_state == ARMED && wr_addr == '1) begin
                    wrapped <= 1'b1;
                end
            end
            if (trig_now) begin
                trigger_addr <= wr_addr;
                post_cnt     <= post_trig_cnt;
            end else if (wr_now && cur_state == POST) begin
                post_cnt <= post_cnt - 1'b1;
            end
            if (stop_now) begin
                stop_addr <= wr_addr;
            end
        end
    end

`ifdef ICETAP_TIMESTAMP_EN
    // Saturating cycles-since-last-write counter
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ts <= '0;
        end else if (arm_now) begin
            ts <= '0;
        end else if (wr_now) begin
            ts <= TS_BITS'(1);
        end else if (ts != '1) begin
            ts <= ts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Self-checking bench for icetap_capture_ctrl (8 signals, 256-deep RAM).
// A transaction-level model predicts every registered output; directed
// scenarios add hand-computed literal expectations.
module tb_icetap_capture_ctrl;

    localparam int NS    = 8;
    localparam int AB    = 8;
    localparam int TB    = 8;
    localparam int DEPTH = 256;
`ifdef ICETAP_TIMESTAMP_EN
    localparam int DW = NS + TB;
`else
    localparam int DW = NS;
`endif

    logic          clk = 1'b0;
    logic          reset_ = 1'b1;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [23:0]   store_mask = '0;
    logic [23:0]   trigger_mask = '0;
    logic [7:0]    post_trig_cnt = '0;
    logic [7:0]    signals_in = '0;
    logic          ram_wr_ena;
    logic [7:0]    ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [1:0]    state;
    logic          wrapped;
    logic [7:0]    trigger_addr;
    logic [7:0]    stop_addr;

    icetap_capture_ctrl #(
        .NR_SIGNALS (NS),
        .ADDR_BITS  (AB),
        .TS_BITS    (TB)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .store_mask    (store_mask),
        .trigger_mask  (trigger_mask),
        .post_trig_cnt (post_trig_cnt),
        .signals_in    (signals_in),
        .ram_wr_ena    (ram_wr_ena),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .state         (state),
        .wrapped       (wrapped),
        .trigger_addr  (trigger_addr),
        .stop_addr     (stop_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // What each qualifier code demands of one signal
    function automatic bit qual(input logic [2:0] code, input logic cur, input logic prev);
        case (code)
            3'd1:    return cur == 1'b1;
            3'd2:    return cur == 1'b0;
            3'd3:    return cur != prev;
            3'd5:    return (cur == 1'b1) && (prev == 1'b0);
            3'd6:    return (cur == 1'b0) && (prev == 1'b1);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit all_qual(input logic [23:0] mask, input logic [7:0] cur, input logic [7:0] prev);
        bit ok = 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (!qual(mask[3*i +: 3], cur[i], prev[i])) ok = 1'b0;
        end
        return ok;
    endfunction

    // phase: 0 idle, 1 armed, 2 post, 3 done
    int            m_phase;
    int            m_nwr;      // writes since arming
    int            m_remain;   // post-trigger writes still owed
    logic [7:0]    m_trig;
    logic [7:0]    m_stop;
    bit            m_wrapped;
    logic [7:0]    m_s1;
    logic [7:0]    m_s2;
    longint        m_cyc;      // edges since reset
    longint        ref_cyc;    // edge at which ts last held ref_val
    int            ref_val;
    bit            e_ena;
    logic [7:0]    e_addr;
    logic [DW-1:0] e_data;

    task automatic m_reset();
        m_phase = 0; m_nwr = 0; m_remain = 0;
        m_trig = '0; m_stop = '0; m_wrapped = 1'b0;
        m_s1 = '0; m_s2 = '0;
        m_cyc = 0; ref_cyc = 1; ref_val = 0;
        e_ena = 1'b0; e_addr = '0; e_data = '0;
    endtask

    task automatic emit(input logic [7:0] a, input int ts_now);
        e_ena  = 1'b1;
        e_addr = a;
`ifdef ICETAP_TIMESTAMP_EN
        e_data = {8'(ts_now), m_s1};
`else
        e_data = m_s1;
        if (ts_now < 0) e_data = '0;
`endif
        ref_val = 1;
        ref_cyc = m_cyc + 1;
    endtask

    task automatic m_step();
        bit         sh;
        bit         th;
        int         ts_now;
        logic [7:0] a;
        m_cyc++;
        ts_now = ref_val + int'(m_cyc - ref_cyc);
        if (ts_now > 255) ts_now = 255;
        sh = all_qual(store_mask, m_s1, m_s2);
        th = all_qual(trigger_mask, m_s1, m_s2);
        e_ena = 1'b0;
        if (cmd_abort) begin
            m_phase = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (cmd_start) begin
                m_phase = 1; m_nwr = 0; m_wrapped = 1'b0;
                ref_val = 0; ref_cyc = m_cyc + 1;
            end
        end else if (m_phase == 1) begin
            if (sh || th) begin
                a = 8'(m_nwr % DEPTH);
                emit(a, ts_now);
                m_nwr++;
                if (m_nwr >= DEPTH) m_wrapped = 1'b1;
                if (th) begin
                    m_trig = a;
                    if (post_trig_cnt == 8'd0) begin
                        m_stop = a; m_phase = 3;
                    end else begin
                        m_remain = int'(post_trig_cnt); m_phase = 2;
                    end
                end
            end
        end else begin
            if (sh) begin
                a = 8'(m_nwr % DEPTH);
                emit(a, ts_now);
                m_nwr++;
                m_remain--;
                if (m_remain == 0) begin
                    m_stop = a; m_phase = 3;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = signals_in;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_);
            if (!reset_) m_reset();
            else m_step();
        end
    end

    // ---------------- compare + write log ----------------
    int            wr_seen = 0;
    logic [7:0]    log_addr [1024];
    bit            log_wrap [1024];
    logic [DW-1:0] log_data [1024];

    initial begin
        forever begin
            @(negedge clk);
            if (ram_wr_ena === 1'b1) begin
                if (wr_seen < 1024) begin
                    log_addr[wr_seen] = ram_wr_addr;
                    log_wrap[wr_seen] = wrapped;
                    log_data[wr_seen] = ram_wr_data;
                end
                wr_seen++;
            end
            check("ram_wr_ena", 64'(ram_wr_ena), 64'(e_ena));
            if (e_ena) begin
                check("ram_wr_addr", 64'(ram_wr_addr), 64'(e_addr));
                check("ram_wr_data", 64'(ram_wr_data), 64'(e_data));
            end
            check("state", 64'(state), 64'(m_phase));
            check("wrapped", 64'(wrapped), 64'(m_wrapped));
            check("trigger_addr", 64'(trigger_addr), 64'(m_trig));
            check("stop_addr", 64'(stop_addr), 64'(m_stop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_abort();
        cyc(); cmd_abort = 1'b1;
        cyc(); cmd_abort = 1'b0;
        cyc();
        check("abort_to_idle", 64'(state), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tv;
        int         last;

        // 1: reset held with toggling inputs
        #1 reset_ = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(); signals_in = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        end
        check("rst_state", 64'(state), 64'd0);
        check("rst_ena", 64'(ram_wr_ena), 64'd0);
        check("rst_addr", 64'(ram_wr_addr), 64'd0);
        check("rst_data", 64'(ram_wr_data), 64'd0);
        check("rst_trig", 64'(trigger_addr), 64'd0);
        check("rst_stop", 64'(stop_addr), 64'd0);
        check("rst_wrapped", 64'(wrapped), 64'd0);
        cyc(); reset_ = 1'b1;
        cyc(); cyc();

        // 2: counter, store always, trigger on bit7 high, post=4
        cyc();
        store_mask = 24'h0; trigger_mask = 24'h200000; post_trig_cnt = 8'd4;
        signals_in = 8'h00; cmd_start = 1'b1; wr_seen = 0;
        for (int t = 1; t < 400; t++) begin
            cyc(); cmd_start = 1'b0;
            if (state == 2'd3) break;
            signals_in = 8'(t);
        end
        check("t2_done", 64'(state), 64'd3);
        check("t2_writes", 64'(wr_seen), 64'd133);
        check("t2_trig_addr", 64'(trigger_addr), 64'h80);
        check("t2_stop_addr", 64'(stop_addr), 64'h84);
        check("t2_trig_sample", 64'(log_data[128][7:0]), 64'h80);
        check("t2_trig_log_addr", 64'(log_addr[128]), 64'h80);
        check("t2_wrapped", 64'(wrapped), 64'd0);

        // 3: store odd samples only, trigger impossible, run past the wrap
        cyc();
        store_mask = 24'h000001; trigger_mask = 24'h000011; post_trig_cnt = 8'd0;
        signals_in = 8'h00; cmd_start = 1'b1; wr_seen = 0;
        for (int t = 1; t < 800; t++) begin
            cyc(); cmd_start = 1'b0;
            if (wr_seen >= 257) break;
            tv = 8'(t);
            signals_in = {tv[7:2], tv[0], tv[0]};
        end
        check("t3_writes", 64'(wr_seen), 64'd257);
        check("t3_odd_sample", 64'(log_data[5][0]), 64'd1);
        check("t3_wrap_before", 64'(log_wrap[254]), 64'd0);
        check("t3_addr_top", 64'(log_addr[255]), 64'd255);
        check("t3_wrap_set", 64'(log_wrap[255]), 64'd1);
        check("t3_addr_back0", 64'(log_addr[256]), 64'd0);
        check("t3_state", 64'(state), 64'd1);
        do_abort();

        // 4: rising-edge trigger on sig1, post=0, store never true
        cyc();
        store_mask = 24'h000040; trigger_mask = 24'h000028; post_trig_cnt = 8'd0;
        signals_in = 8'h00; cmd_start = 1'b1; wr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); cmd_start = 1'b0; signals_in = 8'h00;
        end
        cyc(); signals_in = 8'h02;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (state == 2'd3) break;
        end
        check("t4_done", 64'(state), 64'd3);
        cyc(); cyc(); cyc();
        check("t4_writes", 64'(wr_seen), 64'd1);
        check("t4_sample", 64'(log_data[0][7:0]), 64'h02);
        check("t4_addr", 64'(log_addr[0]), 64'd0);
        check("t4_trig_addr", 64'(trigger_addr), 64'd0);
        check("t4_stop_addr", 64'(stop_addr), 64'd0);

        // 5: abort in POST, then start+abort together
        cyc();
        store_mask = 24'h0; trigger_mask = 24'h200000; post_trig_cnt = 8'd200;
        signals_in = 8'h7E; cmd_start = 1'b1; wr_seen = 0;
        for (int t = 1; t <= 6; t++) begin
            cyc(); cmd_start = 1'b0; signals_in = 8'(8'h7E + t);
        end
        check("t5_post", 64'(state), 64'd2);
        check("t5_trig_addr", 64'(trigger_addr), 64'd2);
        do_abort();
        cyc(); cmd_start = 1'b1; cmd_abort = 1'b1;
        cyc(); cmd_start = 1'b0; cmd_abort = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("t5_writes", 64'(wr_seen), 64'd6);
        check("t5_idle", 64'(state), 64'd0);

`ifdef ICETAP_TIMESTAMP_EN
        // 6: timestamp deltas and saturation
        cyc();
        store_mask = 24'h000001; trigger_mask = 24'h200000; post_trig_cnt = 8'd0;
        signals_in = 8'h00; cmd_start = 1'b1; wr_seen = 0;
        for (int t = 1; t <= 20; t++) begin
            cyc(); cmd_start = 1'b0; signals_in = 8'(t) & 8'h7F;
        end
        check("t6_ts_first", 64'(log_data[0][15:8]), 64'd1);
        check("t6_ts_1", 64'(log_data[1][15:8]), 64'd2);
        check("t6_ts_2", 64'(log_data[2][15:8]), 64'd2);
        for (int i = 0; i < 300; i++) begin
            cyc(); signals_in = 8'h00;
        end
        cyc(); signals_in = 8'h01;
        cyc(); cyc(); signals_in = 8'h00;
        cyc();
        last = wr_seen - 1;
        check("t6_ts_sat", 64'(log_data[last][15:8]), 64'hFF);
        do_abort();
`endif

        // reset asserted mid-capture, away from a clock edge
        cyc();
        store_mask = 24'h0; trigger_mask = 24'h200000; post_trig_cnt = 8'd0;
        signals_in = 8'h00; cmd_start = 1'b1;
        cyc(); cmd_start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("mid_writing", 64'(ram_wr_ena), 64'd1);
        @(posedge clk);
        #3 reset_ = 1'b0;
        #1;
        check("mid_rst_ena", 64'(ram_wr_ena), 64'd0);
        check("mid_rst_state", 64'(state), 64'd0);
        cyc(); cyc(); reset_ = 1'b1;
        cyc(); cyc();
        check("post_rst_state", 64'(state), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
